// File: rtl/histo_eq_reader.sv
`default_nettype none
// ============================================================================
// Module      : histo_eq_reader
// Description : Scans the 256-bin histogram after each frame, builds the
//               equalisation LUT from the scaled cumulative sum and records
//               the most populated bin.
// Revision    : 1.0 - initial release
// ============================================================================
module histo_eq_reader #(
    parameter int BIN_W    = 20,
    parameter int PIX_LOG2 = 10,
    parameter int ACC_W    = BIN_W + 8
) (
    input  logic             iPclk,
    input  logic             iRST_N,
    input  logic             iFval,
    output logic [7:0]       oRd_addr,
    output logic             oRd_en,
    input  logic [BIN_W-1:0] iRd_data,
    output logic             oLut_we,
    output logic [7:0]       oLut_addr,
    output logic [7:0]       oLut_data,
    output logic             oBusy,
    output logic             oDone,
    output logic             oAbort,
    output logic [7:0]       oMax_bin,
    output logic [BIN_W-1:0] oMax_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_fval;
    logic              r_fval_d;
    logic              w_fall;
    logic              w_rise;
    logic              w_start;
    logic              w_abort;
    logic              w_take;

    logic [7:0]        r_rd_addr;
    logic              r_drain_cnt;
    logic              r_rd_vld;
    logic [7:0]        r_rd_idx;

    logic [ACC_W-1:0]  r_cum;
    logic [ACC_W-1:0]  w_cum_nxt;
    logic [ACC_W+7:0]  w_prod;
    logic [ACC_W+7:0]  w_scaled;
    logic [7:0]        w_lut_val;

    logic              r_lut_we;
    logic [7:0]        r_lut_addr;
    logic [7:0]        r_lut_data;
    logic              r_abort;
    logic [7:0]        r_run_max_bin;
    logic [BIN_W-1:0]  r_run_max_cnt;
    logic [7:0]        r_max_bin;
    logic [BIN_W-1:0]  r_max_cnt;

    assign w_fall  = r_fval_d & ~r_fval;
    assign w_rise  = ~r_fval_d & r_fval;
    assign w_start = (r_state == S_IDLE) && w_fall;
    assign w_abort = w_rise && ((r_state == S_READ) || (r_state == S_DRAIN));
    // Data returning in the abort cycle is discarded so no write follows it
    assign w_take  = r_rd_vld && !w_abort;

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_fval   <= 1'b0;
            r_fval_d <= 1'b0;
        end else begin
            r_fval   <= iFval;
            r_fval_d <= r_fval;
        end
    end

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_rd_addr == 8'hFF) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_drain_cnt) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_rd_addr   <= 8'd0;
            r_drain_cnt <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_idx    <= 8'd0;
        end else begin
            if ((r_state == S_READ) && (w_state_nxt == S_READ)) begin
                r_rd_addr <= r_rd_addr + 8'd1;
            end else begin
                r_rd_addr <= 8'd0;
            end
            if ((r_state == S_DRAIN) && !w_abort) begin
                r_drain_cnt <= ~r_drain_cnt;
            end else begin
                r_drain_cnt <= 1'b0;
            end
            r_rd_vld <= (r_state == S_READ) && !w_abort;
            r_rd_idx <= r_rd_addr;
        end
    end

    // LUT value = cum*255 / 2^PIX_LOG2, saturated to 8 bits
    assign w_cum_nxt = r_cum + {{(ACC_W-BIN_W){1'b0}}, iRd_data};
    assign w_prod    = {w_cum_nxt, 8'd0} - {8'd0, w_cum_nxt};
    assign w_scaled  = w_prod >> PIX_LOG2;
    assign w_lut_val = (|w_scaled[ACC_W+7:8]) ? 8'hFF : w_scaled[7:0];

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cum         <= '0;
            r_lut_we      <= 1'b0;
            r_lut_addr    <= 8'd0;
            r_lut_data    <= 8'd0;
            r_run_max_bin <= 8'd0;
            r_run_max_cnt <= '0;
        end else begin
            r_lut_we <= w_take;
            if (w_start) begin
                r_cum         <= '0;
                r_run_max_bin <= 8'd0;
                r_run_max_cnt <= '0;
            end else if (w_take) begin
                r_cum      <= w_cum_nxt;
                r_lut_addr <= r_rd_idx;
                r_lut_data <= w_lut_val;
                // Strictly greater keeps the lowest index on ties
                if (iRd_data > r_run_max_cnt) begin
                    r_run_max_bin <= r_rd_idx;
                    r_run_max_cnt <= iRd_data;
                end
            end
        end
    end

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            r_abort   <= 1'b0;
            r_max_bin <= 8'd0;
            r_max_cnt <= '0;
        end else begin
            r_abort <= w_abort;
            if (r_state == S_DONE) begin
                r_max_bin <= r_run_max_bin;
                r_max_cnt <= r_run_max_cnt;
            end
        end
    end

    assign oRd_en    = (r_state == S_READ);
    assign oRd_addr  = r_rd_addr;
    assign oLut_we   = r_lut_we;
    assign oLut_addr = r_lut_addr;
    assign oLut_data = r_lut_data;
    assign oBusy     = (r_state != S_IDLE);
    assign oDone     = (r_state == S_DONE);
    assign oAbort    = r_abort;
    assign oMax_bin  = r_max_bin;
    assign oMax_cnt  = r_max_cnt;

endmodule
`default_nettype wire
